// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: data width, default bit period and
//               the receiver state encoding. The default bit period is also
//               used by the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS            = 8;
  // 100 MHz / 9600 baud
  localparam int CLKS_PER_BIT_DEFAULT = 10416;

  // PARITY is only entered when the receiver is built with UART_RX_PARITY_EN.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial line plus a
//               falling-edge detector on the synchronized value. All flops
//               reset to 1 (idle line) so reset release never looks like a
//               start edge.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               rxd    - raw serial line
//               rxd_s  - synchronized line
//               fall   - high for one cycle when rxd_s goes 1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rxd;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxd_s = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : UART receiver, 8 data bits LSB first, 1 stop bit, idle-high
//               line. Received bytes are presented on a valid/ready holding
//               register; framing errors and overruns are one-cycle pulses.
// Config      : UART_RX_PARITY_EN - when defined, an even-parity bit is
//               expected between the data and stop bits (8E1); otherwise 8N1.
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               rxd       - asynchronous serial input, idle high
//               rx_data   - last accepted byte, stable while rx_valid = 1
//               rx_valid  - holding register full
//               rx_ready  - consumer accepts the byte
//               frame_err - pulse: bad stop bit (or parity mismatch)
//               overrun   - pulse: byte completed while rx_valid = 1
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIDX_W-1:0] BIT_LAST = BIDX_W'(DATA_BITS - 1);

  logic rxd_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  // Stop-bit result is registered once, then resolved into the holding
  // register / error pulses on the following cycle.
  logic                  done_q, done_d;
  logic                  ok_q, ok_d;
  logic [DATA_BITS-1:0]  rx_data_q;
  logic                  rx_valid_q;
  logic                  frame_err_q;
  logic                  overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                  par_ok_q, par_ok_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    ok_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_d  = par_ok_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        // Re-check the line at mid start bit; a high line means a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          shreg_d   = {rxd_s, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIDX_W'(1);
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d    = '0;
          // Even parity: the parity bit equals the XOR of the data bits.
          par_ok_d = (rxd_s == ^shreg_q);
          state_d  = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
          ok_d    = rxd_s & par_ok_q;
`else
          ok_d    = rxd_s;
`endif
          // Back to IDLE at mid stop bit so the next start edge is seen.
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
`ifdef UART_RX_PARITY_EN
      par_ok_q  <= par_ok_d;
`endif
    end
  end

  // Holding register. A consume in the same cycle as a completion frees the
  // slot, so the new byte is loaded without an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (done_q) begin
        if (!ok_q) begin
          frame_err_q <= 1'b1;
        end else if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shreg_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire
